// File: rtl/arb_defs.sv
// Shared definitions for the round-robin select arbiter in front of the 4:1 mux.
package arb_defs;

   localparam int NREQ  = 4;   // requester count, tied to the 4:1 mux width
   localparam int SEL_W = 2;   // mux select width
   localparam int CNT_W = 4;   // burst counter width

   // Saturation value of the burst counter (only reachable with lock held).
   localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

   // Arbiter state: IDLE has nothing presented, BUSY presents a word to the consumer.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Rotating first-set-bit search over four requests, starting at index 'start'
// and wrapping mod 4. 'any' is low when no request bit is set.
module rr_pick4
   import arb_defs::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] start,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   // Scan from the farthest offset back to 'start' so the nearest hit wins.
   always_comb begin
      logic [SEL_W-1:0] cand;
      cand = '0;
      idx  = start;
      any  = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = start + SEL_W'(i);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of the downstream 4:1 case mux.
// Holds sel stable under backpressure, pulses a one-hot gnt on each transfer,
// and limits back-to-back transfers per requester to MAX_BURST.
// Optional macro ARB_LOCK_EN adds a 'lock' input that lets the current
// requester keep the mux past MAX_BURST (burst_cnt saturates at 15).
//
// Handshake: a transfer happens in any cycle with out_valid=1 and out_ready=1;
// gnt[sel] is high exactly in that cycle. While out_valid=1 and out_ready=0,
// sel/out_valid/burst_cnt do not change. A requester keeps req high until its
// gnt bit pulses; req[sel] seen during the transfer cycle means "another beat".
module mux_sel_arbiter
   import arb_defs::*;
#(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 2,
   parameter int PTR_RST   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   input  logic [3:0]       req,
   input  logic             out_ready,
   output logic [SEL_W-1:0] sel,
   output logic             out_valid,
   output logic [3:0]       gnt,
   output logic [CNT_W-1:0] burst_cnt
);

   // Elaboration-time legality checks on the parameters.
   if (NREQ != arb_defs::NREQ) begin : g_bad_nreq
      $error("mux_sel_arbiter: NREQ must be 4 to match the 4:1 mux");
   end
   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("mux_sel_arbiter: MAX_BURST must be in 1..15");
   end
   if (PTR_RST < 0 || PTR_RST > 3) begin : g_bad_ptr
      $error("mux_sel_arbiter: PTR_RST must be in 0..3");
   end

   localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(PTR_RST);
   localparam logic [CNT_W:0]   MAX_B    = (CNT_W + 1)'(MAX_BURST);

   arb_state_e       state_q, state_n;
   logic [SEL_W-1:0] sel_q, sel_n;
   logic [SEL_W-1:0] ptr_q, ptr_n;
   logic [CNT_W-1:0] burst_q, burst_n;

   logic [SEL_W-1:0] pick_start;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             xfer;
   logic             lock_keep;
   logic [CNT_W:0]   burst_inc;

   // IDLE searches from the pointer; BUSY searches from the slot after the winner.
   assign pick_start = (state_q == ST_IDLE) ? ptr_q : SEL_W'(sel_q + 2'd1);

   rr_pick4 u_pick (
      .req   (req),
      .start (pick_start),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign xfer      = (state_q == ST_BUSY) && out_ready;
   assign burst_inc = {1'b0, burst_q} + (CNT_W + 1)'(1);

`ifdef ARB_LOCK_EN
   assign lock_keep = lock && req[sel_q];
`else
   assign lock_keep = 1'b0;
`endif

   // State, select, pointer and burst count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= PTR_INIT;
         ptr_q   <= PTR_INIT;
         burst_q <= '0;
      end else begin
         state_q <= state_n;
         sel_q   <= sel_n;
         ptr_q   <= ptr_n;
         burst_q <= burst_n;
      end
   end

   // Next-state logic: start a burst from IDLE, hold under backpressure,
   // extend or rotate on each transfer.
   always_comb begin
      state_n = state_q;
      sel_n   = sel_q;
      ptr_n   = ptr_q;
      burst_n = burst_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               sel_n   = pick_idx;
               burst_n = '0;
               state_n = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (xfer) begin
               if (lock_keep) begin
                  burst_n = (burst_q == CNT_MAX) ? CNT_MAX : burst_inc[CNT_W-1:0];
               end else if (req[sel_q] && (burst_inc < MAX_B)) begin
                  burst_n = burst_inc[CNT_W-1:0];
               end else begin
                  // Rotation: the search starts after the winner, so it only
                  // comes back to the same requester when nobody else asks.
                  ptr_n   = SEL_W'(sel_q + 2'd1);
                  burst_n = '0;
                  if (pick_any) begin
                     sel_n = pick_idx;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign sel       = sel_q;
   assign out_valid = (state_q == ST_BUSY);
   assign burst_cnt = burst_q;
   assign gnt       = xfer ? (4'b0001 << sel_q) : 4'b0000;

endmodule
